// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master bridge
package apb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 8;
    localparam int SLV_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait counter with terminal count at TIMEOUT-1
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(TIMEOUT - 1));

    // Holds at terminal count so the counter never wraps.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/apb_m.sv
// rtl/apb_m.sv - APB3 master bridging a valid/ready command port to SETUP/ACCESS transfers
module apb_m
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t state, next_state;
    logic       tmr_clr, tmr_en, tmr_tc;
    logic       done_ok, done_to;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .pclk   (pclk),
        .preset (preset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc     (tmr_tc)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The bus pins are registered, so the FSM runs one cycle ahead of them:
    // ACCESS only samples the slave once penable is actually on the bus.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (penable && (pready || tmr_tc)) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        tmr_clr   = (state == SETUP);
        tmr_en    = (state == ACCESS) && penable && !pready;
        done_ok   = (state == ACCESS) && penable && pready;
        done_to   = (state == ACCESS) && penable && !pready && tmr_tc;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end
            psel    <= (next_state == ACCESS);
            penable <= (state == ACCESS) && (next_state == ACCESS);
            if (done_ok) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= (pwrite || pslverr) ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (done_to) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_m.sv
// tb/tb_apb_m.sv - directed self-checking bench for apb_m with a behavioural 16-entry APB slave
module tb_apb_m;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pready, pslverr;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [SLV_DEPTH];
    int         acc_cnt = 0;
    int         slv_waits = 0;
    logic       slv_hang = 1'b0;

    apb_m dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave: ready after slv_waits low-pready ACCESS cycles, error on out-of-range address.
    assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_waits);
    assign pslverr = psel && penable && (paddr >= 32'(SLV_DEPTH));
    assign prdata  = (paddr < 32'(SLV_DEPTH)) ? mem[paddr[3:0]] : 8'hEE;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && paddr < 32'(SLV_DEPTH))
            mem[paddr[3:0]] <= pwdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [7:0] d,
                           output int lat, output int psel_n, output int pen_n);
        int got;
        int wait_n;
        got = 0;
        lat = 0;
        psel_n = 0;
        pen_n = 0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge pclk);
            wait_n++;
        end
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge pclk);
            #1;
            lat++;
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (psel) psel_n++;
            if (penable) pen_n++;
        end
        chk("rsp_arrived", 32'(got), 32'd1);
    endtask

    task automatic finish_rsp(input string tag);
        @(posedge pclk);
        #1;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int lat, ps, pe;
        logic [7:0] held;

        repeat (2) @(posedge pclk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel", {30'd0, psel, penable}, 32'd0);
        chk("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 32'd0);
        chk("rst_bus", paddr ^ {23'd0, pwrite, pwdata}, 32'd0);
        @(negedge pclk);
        preset = 1'b0;

        do_xfer(1'b1, 32'h5, 8'hA7, lat, ps, pe);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_psel_cycles", 32'(ps), 32'd2);
        chk("wr_penable_cycles", 32'(pe), 32'd1);
        chk("wr_rsp", {23'd0, rsp_err, rsp_timeout, rsp_rdata}, 32'd0);
        chk("wr_psel_low", {30'd0, psel, penable}, 32'd0);
        finish_rsp("wr");

        do_xfer(1'b0, 32'h5, 8'h00, lat, ps, pe);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_psel_cycles", 32'(ps), 32'd2);
        chk("rd_penable_cycles", 32'(pe), 32'd1);
        chk("rd_rdata", 32'(rsp_rdata), 32'hA7);
        chk("rd_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        finish_rsp("rd");

        do_xfer(1'b0, 32'h20, 8'h00, lat, ps, pe);
        chk("oor_err", {30'd0, rsp_err, rsp_timeout}, 32'b10);
        chk("oor_rdata", 32'(rsp_rdata), 32'h00);
        finish_rsp("oor");

        do_xfer(1'b1, 32'h7, 8'h3C, lat, ps, pe);
        finish_rsp("pre3c");
        slv_waits = 4;
        do_xfer(1'b0, 32'h7, 8'h00, lat, ps, pe);
        chk("wait_latency", 32'(lat), 32'd7);
        chk("wait_penable_cycles", 32'(pe), 32'd5);
        chk("wait_rdata", 32'(rsp_rdata), 32'h3C);
        chk("wait_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        finish_rsp("wait");
        slv_waits = 0;

        slv_hang = 1'b1;
        do_xfer(1'b0, 32'h5, 8'h00, lat, ps, pe);
        chk("to_latency", 32'(lat), 32'd18);
        chk("to_penable_cycles", 32'(pe), 32'd16);
        chk("to_flags", {30'd0, rsp_err, rsp_timeout}, 32'b11);
        chk("to_rdata", 32'(rsp_rdata), 32'h00);
        chk("to_psel", 32'(psel), 32'd0);
        finish_rsp("to");
        slv_hang = 1'b0;

        rsp_ready = 1'b0;
        do_xfer(1'b0, 32'h5, 8'h00, lat, ps, pe);
        held = rsp_rdata;
        chk("bp_rdata", 32'(held), 32'hA7);
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk);
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_rsp", {22'd0, rsp_err, rsp_timeout, rsp_rdata}, {22'd0, 2'b00, 8'hA7});
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h2;
        cmd_wdata = 8'h55;
        @(posedge pclk);
        #1;
        chk("bp_hs_ready", 32'(cmd_ready), 32'd1);
        chk("bp_hs_psel", 32'(psel), 32'd0);
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        chk("bp_next_accept", 32'(cmd_ready), 32'd0);
        @(posedge pclk);
        #1;
        chk("bp_next_psel", 32'(psel), 32'd1);
        repeat (2) @(posedge pclk);
        #1;
        chk("bp_next_rsp", 32'(rsp_valid), 32'd1);
        finish_rsp("bp_next");

        slv_hang = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h2;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_mid_in_access", {30'd0, psel, penable}, 32'b11);
        #2 preset = 1'b1;
        #1;
        chk("rst_mid_bus", {30'd0, psel, penable}, 32'd0);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_mid_idle", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        preset = 1'b0;
        slv_hang = 1'b0;

        do_xfer(1'b1, 32'h1, 8'h11, lat, ps, pe);
        chk("post_wr_latency", 32'(lat), 32'd3);
        chk("post_wr_err", 32'(rsp_err), 32'd0);
        finish_rsp("post_wr");
        do_xfer(1'b0, 32'h1, 8'h00, lat, ps, pe);
        chk("post_rd_rdata", 32'(rsp_rdata), 32'h11);
        chk("post_rd_mem2", 32'(mem[2]), 32'h55);
        finish_rsp("post_rd");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/apb_m.md
# apb_m

APB master bridge that converts a simple valid/ready command interface into APB3 SETUP/ACCESS transfers toward the 8-bit-data, 16-entry APB slave. It sits directly upstream of that slave: it drives the slave's paddr/psel/penable/pwrite/pwdata and consumes its prdata/pready/pslverr. Each transfer returns one response carrying read data and error status. A bounded wait-state timeout guarantees that a stalled slave cannot hang the master.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, maximum ACCESS cycles without pready before a forced abort (≥2)

- pclk  in  1  APB clock; all logic is on the rising edge
- preset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored transfers
- rsp_err  out  1  pslverr sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: latch write, addr, and wdata onto pwrite, paddr, and pwdata, then go to SETUP.
- SETUP
  - psel=1, penable=0; unconditionally go to ACCESS.
  - Clear the wait counter.
- ACCESS
  - psel=1, penable=1.
  - If pready=1: capture the response, then go to RESP.
    - rsp_rdata = pwrite ? 0 : (pslverr ? 0 : prdata).
    - rsp_err = pslverr; rsp_timeout = 0.
  - Else if wait counter == TIMEOUT-1: abort and go to RESP.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Else increment the wait counter.
- RESP
  - psel=0, penable=0; rsp_valid=1.
  - Hold all rsp_* outputs stable until rsp_ready=1, then go to IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Only one transfer is outstanding at a time.
- paddr, pwrite and pwdata stay stable from SETUP through the last ACCESS cycle. After the transfer they hold their last values.
- All outputs are registered except cmd_ready, which is decoded from state.
- Reset, asynchronous and effective at any state including mid-transfer:
  - state=IDLE, wait counter=0.
  - psel, penable, pwrite, paddr and pwdata are 0.
  - rsp_valid, rsp_err, rsp_timeout and rsp_rdata are 0.
  - Any in-flight command is dropped with no response.
- The wait counter is $clog2(TIMEOUT) bits and saturates; it never wraps.

## Timing
- Command accepted at edge 0 (cmd_valid && cmd_ready).
- Edge 1: SETUP (psel=1).
- Edge 2: ACCESS (penable=1).
- Zero-wait slave: pready is sampled high at edge 3, and rsp_valid=1 after edge 3. Minimum latency is 3 cycles from acceptance to response.
- Each low-pready ACCESS cycle adds one cycle of latency.
- Timeout: rsp_valid rises TIMEOUT ACCESS cycles after entering ACCESS.
- psel/penable fall in the same edge that raises rsp_valid. The slave therefore sees exactly one ACCESS cycle with pready=1.
- rsp_valid && rsp_ready at edge N returns the FSM to IDLE. A new command is accepted at edge N+1 at the earliest.
- pready or pslverr asserted outside ACCESS is ignored.

## Structure
- Shared package apb_pkg contains:
  - the state typedef (enum logic [1:0] {IDLE, SETUP, ACCESS, RESP});
  - the ADDR_W/DATA_W defaults;
  - the slave memory depth constant (16), which benches use to pick out-of-range addresses.
- One natural sub-module: apb_wait_timer, a saturating counter with clear, enable, and a terminal-count output of TIMEOUT-1.
- The FSM and datapath registers stay in apb_m.

## Test plan
- Write then read, addr 0x5, data 0xA7:
  - psel is high for 2 cycles per transfer, with penable high in the second cycle.
  - Read response: rsp_rdata=0xA7, rsp_err=0.
  - Latency 3 cycles from acceptance.
- Out-of-range read, addr 0x20 → rsp_err=1 (from pslverr), rsp_rdata=0x00, rsp_timeout=0.
- Slave model holds pready low for 4 ACCESS cycles, then returns 0x3C → 4 extra latency cycles, rsp_rdata=0x3C, no timeout.
- Slave model never raises pready, TIMEOUT=16 → after 16 ACCESS cycles: rsp_err=1, rsp_timeout=1, psel=0.
- rsp_ready held low for 5 cycles → rsp_* outputs stay stable, cmd_ready=0 throughout; a new command is accepted on the cycle after the handshake.
- preset pulsed during ACCESS → psel=penable=0 and rsp_valid=0 immediately; a subsequent write to 0x1, data 0x11 completes normally.
